// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, the response-owner encoding and the default fetch-streak limit
// for the FE/MEM single-port RAM arbiter.
// Optional build macro: MEM_ARB_STATS_EN (adds stall / forced-grant counters).
package mem_port_arbiter_pkg;

    localparam int DBITS          = 32;
    localparam int ADDR_BITS      = 16;
    localparam int WORD_BITS      = 2;
    localparam int RAM_ABITS      = ADDR_BITS - WORD_BITS;
    localparam int BE_BITS        = DBITS / 8;
    localparam int STREAK_BITS    = 4;
    localparam int MAX_STREAK_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_FE   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    // RAM word address; the byte-offset bits are dropped, never trapped.
    function automatic logic [RAM_ABITS-1:0] word_addr(input logic [ADDR_BITS-1:0] a);
        return a[ADDR_BITS-1:WORD_BITS];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and RAM-side bus of the FE/MEM memory port arbiter.
// master = pipeline + RAM side, slave = arbiter.
// Optional build macro: MEM_ARB_STATS_EN (adds stat_fe_stall / stat_forced).
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic                 fe_req_valid;
    logic [ADDR_BITS-1:0] fe_req_addr;
    logic                 fe_req_ready;
    logic                 fe_flush;
    logic                 fe_rsp_valid;
    logic [DBITS-1:0]     fe_rsp_data;

    logic                 dm_req_valid;
    logic                 dm_req_we;
    logic [ADDR_BITS-1:0] dm_req_addr;
    logic [DBITS-1:0]     dm_req_wdata;
    logic [BE_BITS-1:0]   dm_req_be;
    logic                 dm_req_ready;
    logic                 dm_rsp_valid;
    logic [DBITS-1:0]     dm_rsp_data;

    logic                 ram_en;
    logic                 ram_we;
    logic [RAM_ABITS-1:0] ram_addr;
    logic [BE_BITS-1:0]   ram_be;
    logic [DBITS-1:0]     ram_wdata;
    logic [DBITS-1:0]     ram_rdata;

`ifdef MEM_ARB_STATS_EN
    logic [31:0]          stat_fe_stall;
    logic [31:0]          stat_forced;
`endif

    modport master (
        output fe_req_valid, fe_req_addr, fe_flush,
        output dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_req_be,
        output ram_rdata,
        input  fe_req_ready, fe_rsp_valid, fe_rsp_data,
        input  dm_req_ready, dm_rsp_valid, dm_rsp_data,
        input  ram_en, ram_we, ram_addr, ram_be, ram_wdata
`ifdef MEM_ARB_STATS_EN
        , input stat_fe_stall, stat_forced
`endif
    );

    modport slave (
        input  fe_req_valid, fe_req_addr, fe_flush,
        input  dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_req_be,
        input  ram_rdata,
        output fe_req_ready, fe_rsp_valid, fe_rsp_data,
        output dm_req_ready, dm_rsp_valid, dm_rsp_data,
        output ram_en, ram_we, ram_addr, ram_be, ram_wdata
`ifdef MEM_ARB_STATS_EN
        , output stat_fe_stall, stat_forced
`endif
    );

endinterface

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch and data plus the starvation streak counter.
// Data wins by default; once MAX_STREAK data grants have been taken while fetch
// was waiting, the next contended cycle goes to fetch.
module mem_arb_prio
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = MAX_STREAK_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_fe_valid,
    input  logic                   i_fe_flush,
    input  logic                   i_dm_valid,
    output logic                   o_fe_grant,
    output logic                   o_dm_grant,
    output logic                   o_forced,
    output logic [STREAK_BITS-1:0] o_streak
);

    localparam logic [STREAK_BITS-1:0] LP_MAX = STREAK_BITS'(MAX_STREAK);

    logic [STREAK_BITS-1:0] r_streak;
    logic                   w_fe_req;
    logic                   w_fe_turn;

    // A flushed fetch does not compete at all.
    assign w_fe_req  = i_fe_valid && !i_fe_flush;
    assign w_fe_turn = (r_streak == LP_MAX);

    // One grant per cycle; nothing is granted while reset is held.
    always_comb begin
        o_fe_grant = 1'b0;
        o_dm_grant = 1'b0;
        if (!reset) begin
            if (w_fe_req && (!i_dm_valid || w_fe_turn)) begin
                o_fe_grant = 1'b1;
            end else if (i_dm_valid) begin
                o_dm_grant = 1'b1;
            end
        end
    end

    assign o_forced = o_fe_grant && i_dm_valid;
    assign o_streak = r_streak;

    // Count data grants that made a live fetch wait; a flush cycle holds the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak <= '0;
        end else if (!i_fe_valid || o_fe_grant) begin
            r_streak <= '0;
        end else if (o_dm_grant && !i_fe_flush && (r_streak < LP_MAX)) begin
            r_streak <= r_streak + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM (1-cycle read latency) between the
// FE stage and the MEM stage, and routes each read response to its owner.
// Optional build macro: MEM_ARB_STATS_EN (saturating stall / forced-grant counters).
//
// rsp_owner | meaning
// ----------+----------------------------------------------------
// OWN_NONE  | no read in flight (idle, store, or reset)
// OWN_FE    | fetch read in flight; dropped if fe_flush is high now
// OWN_DM    | load read in flight; returned on dm_rsp_*
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = MAX_STREAK_DEF
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    logic                   w_fe_grant;
    logic                   w_dm_grant;
    logic                   w_forced;
    logic [STREAK_BITS-1:0] w_streak;
    logic                   w_store;
    owner_e                 r_rsp_owner;
    owner_e                 w_owner_next;
    logic                   w_unused;

    mem_arb_prio #(
        .MAX_STREAK (MAX_STREAK)
    ) u_prio (
        .clk        (clk),
        .reset      (reset),
        .i_fe_valid (bus.fe_req_valid),
        .i_fe_flush (bus.fe_flush),
        .i_dm_valid (bus.dm_req_valid),
        .o_fe_grant (w_fe_grant),
        .o_dm_grant (w_dm_grant),
        .o_forced   (w_forced),
        .o_streak   (w_streak)
    );

    assign bus.fe_req_ready = w_fe_grant;
    assign bus.dm_req_ready = w_dm_grant;
    assign w_store          = w_dm_grant && bus.dm_req_we;

    // The granted request drives the RAM in the same cycle.
    always_comb begin
        bus.ram_en    = w_fe_grant || w_dm_grant;
        bus.ram_we    = w_store;
        bus.ram_addr  = w_fe_grant ? word_addr(bus.fe_req_addr) : word_addr(bus.dm_req_addr);
        bus.ram_be    = w_store ? bus.dm_req_be : '0;
        bus.ram_wdata = w_store ? bus.dm_req_wdata : '0;
    end

    // Response owner register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_owner <= OWN_NONE;
        end else begin
            r_rsp_owner <= w_owner_next;
        end
    end

    // Stores produce no response, so only fetch and load grants claim the slot.
    always_comb begin
        w_owner_next = OWN_NONE;
        if (w_fe_grant) begin
            w_owner_next = OWN_FE;
        end else if (w_dm_grant && !bus.dm_req_we) begin
            w_owner_next = OWN_DM;
        end
    end

    // A redirect in the response cycle kills the fetch word already on its way.
    always_comb begin
        bus.fe_rsp_valid = (r_rsp_owner == OWN_FE) && !bus.fe_flush && !reset;
        bus.dm_rsp_valid = (r_rsp_owner == OWN_DM) && !reset;
        bus.fe_rsp_data  = bus.ram_rdata;
        bus.dm_rsp_data  = bus.ram_rdata;
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] r_stat_fe_stall;
    logic [31:0] r_stat_forced;

    // Saturating counts of stalled fetch cycles and forced fetch grants.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_fe_stall <= '0;
            r_stat_forced   <= '0;
        end else begin
            if (bus.fe_req_valid && !w_fe_grant && !bus.fe_flush && (r_stat_fe_stall != '1)) begin
                r_stat_fe_stall <= r_stat_fe_stall + 32'd1;
            end
            if (w_forced && (r_stat_forced != '1)) begin
                r_stat_forced <= r_stat_forced + 32'd1;
            end
        end
    end

    assign bus.stat_fe_stall = r_stat_fe_stall;
    assign bus.stat_forced   = r_stat_forced;

    assign w_unused = ^{bus.fe_req_addr[WORD_BITS-1:0], bus.dm_req_addr[WORD_BITS-1:0], w_streak};
`else
    assign w_unused = ^{bus.fe_req_addr[WORD_BITS-1:0], bus.dm_req_addr[WORD_BITS-1:0], w_streak, w_forced};
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-port synchronous instruction/data RAM between the FE stage (instruction fetch) and the MEM stage (loads/stores).
- The RAM has 1-cycle read latency.
- Returns each read response to its owner and discards fetch responses killed by a branch redirect.
- Sits between FE_STAGE/MEM_STAGE and the unified memory array, replacing the private imem read in FE.

Parameters:
- DBITS, 32, data/instruction word width
- ADDR_BITS, 16, byte-address width on the request ports
- WORD_BITS, 2, log2 bytes per word; RAM word address = addr[ADDR_BITS-1:WORD_BITS]
- MAX_STREAK, 4, consecutive contended data grants before fetch is forced a grant (1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- fe_req_valid  in  1  fetch read request
- fe_req_addr  in  ADDR_BITS  fetch byte address
- fe_req_ready  out  1  fetch request accepted this cycle
- fe_flush  in  1  branch redirect; kills outstanding and same-cycle fetch
- fe_rsp_valid  out  1  fetch data valid
- fe_rsp_data  out  DBITS  instruction word
- dm_req_valid  in  1  data request
- dm_req_we  in  1  1=store, 0=load
- dm_req_addr  in  ADDR_BITS  data byte address
- dm_req_wdata  in  DBITS  store data
- dm_req_be  in  DBITS/8  store byte enables
- dm_req_ready  out  1  data request accepted
- dm_rsp_valid  out  1  load data valid
- dm_rsp_data  out  DBITS  load word
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write
- ram_addr  out  ADDR_BITS-WORD_BITS  RAM word address
- ram_be  out  DBITS/8  RAM byte enables
- ram_wdata  out  DBITS  RAM write data
- ram_rdata  in  DBITS  RAM read data, valid the cycle after a read strobe

Behaviour:
- At most one grant per cycle. Ready signals are combinational from valids, fe_flush, reset and the streak counter.
- While reset is high, both readies are 0 and ram_en=0.
- Priority:
  - Data wins by default.
  - Fetch wins only when both are valid and streak==MAX_STREAK.
  - A lone requester is always granted.
  - fe_flush=1 forces fe_req_ready=0 that cycle.
- Streak counter:
  - Increments on each data grant while fe_req_valid=1 and fe_flush=0.
  - Clears on a fetch grant or whenever fe_req_valid=0.
  - Saturates at MAX_STREAK.
- Grant drives the RAM in the same cycle:
  - ram_en=1, ram_addr=granted addr[ADDR_BITS-1:WORD_BITS].
  - ram_we=dm_req_we for data, 0 for fetch.
  - ram_be/ram_wdata come from dm_req_* on a store; ram_be=0 otherwise.
  - Address low WORD_BITS bits are ignored (no misalignment trap).
- Response owner register rsp_owner ∈ {NONE, FE, DM}:
  - Loaded each cycle: FE on a fetch grant, DM on a load grant, NONE otherwise (stores produce no response).
  - Next cycle: fe_rsp_valid=(rsp_owner==FE) or dm_rsp_valid=(rsp_owner==DM).
  - Response data = ram_rdata.
- Flush kill: fe_flush=1 while rsp_owner==FE sets rsp_owner to NONE for that response, so fe_rsp_valid=0 in the response cycle.
- Fully pipelined: a new request may be granted in the same cycle a response is returned, giving sustained 1 access/cycle.
- Store followed by a load to the same word on the next cycle returns the new data, because the RAM write commits at the grant edge.
- Reset values: rsp_owner=NONE, streak=0, fe_rsp_valid=0, dm_rsp_valid=0.
- Reset asserted mid-operation drops any in-flight response: no rsp_valid in the cycle after reset.

Optional Feature:
- MEM_ARB_STATS_EN defined adds outputs:
  - stat_fe_stall[31:0]: cycles with fe_req_valid && !fe_req_ready && !fe_flush.
  - stat_forced[31:0]: forced fetch grants.
  - Both counters are saturating and clear on reset.
- Undefined: these ports and counters do not exist, and the behaviour is otherwise identical.

Decomposition:
- define.vh holds DBITS, IMEMADDRBITS/IMEMWORDBITS (mapped to ADDR_BITS/WORD_BITS), the owner encoding (OWN_NONE=2'd0, OWN_FE=2'd1, OWN_DM=2'd2) and the default MAX_STREAK.
- One sub-module, mem_arb_prio: the grant decision plus the streak counter.
- The top level holds the RAM muxing, rsp_owner and the optional statistics counters.

Test Plan:
- Fetch only, addr 0x0,0x4,0x8 back-to-back:
  - fe_req_ready=1 each cycle; ram_addr 0,1,2.
  - fe_rsp_valid on cycles +1..+3 with ram_rdata.
- Fetch and load both valid every cycle, MAX_STREAK=4: grant pattern DM,DM,DM,DM,FE repeating; streak returns to 0 after the FE grant.
- Store 0xDEADBEEF be=4'hF to 0x40, then load 0x40 next cycle: dm_rsp_valid one cycle later with 0xDEADBEEF; no response for the store.
- Fetch granted, fe_flush=1 next cycle: fe_rsp_valid stays 0 and fe_req_ready=0 in the flush cycle. Concurrent load unaffected.
- Reset asserted while load in flight: dm_rsp_valid=0 the following cycle; readies 0 during reset; streak=0 after reset.
- MEM_ARB_STATS_EN build, 10-cycle contention with MAX_STREAK=4: stat_forced=2, stat_fe_stall=8.
